// File: rtl/dii_package.sv
// Shared DII flit type and ring arbiter state encoding used by ring routers.
package dii_package;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  typedef enum logic [1:0] {
    IDLE,
    RING,
    LOCAL
  } ring_arb_state_t;

endpackage

// File: rtl/ring_inject_arb_stats.sv
// Per-source forwarded-packet counters with synchronous clear.
// Only built when RING_INJECT_ARB_STATS_EN is defined.
`ifdef RING_INJECT_ARB_STATS_EN
module ring_inject_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_ring,
  input  logic        inc_local,
  output logic [15:0] ring_pkts,
  output logic [15:0] local_pkts
);

  logic [15:0] ring_pkts_q, ring_pkts_d;
  logic [15:0] local_pkts_q, local_pkts_d;

  // Clear wins over a same-cycle increment; counters wrap at 16 bits.
  always_comb begin
    ring_pkts_d  = ring_pkts_q;
    local_pkts_d = local_pkts_q;
    if (clr) begin
      ring_pkts_d  = '0;
      local_pkts_d = '0;
    end else begin
      if (inc_ring)  ring_pkts_d  = ring_pkts_q + 16'd1;
      if (inc_local) local_pkts_d = local_pkts_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_pkts_q  <= '0;
      local_pkts_q <= '0;
    end else begin
      ring_pkts_q  <= ring_pkts_d;
      local_pkts_q <= local_pkts_d;
    end
  end

  assign ring_pkts  = ring_pkts_q;
  assign local_pkts = local_pkts_q;

endmodule
`endif

// File: rtl/ring_inject_arb.sv
// Packet-granular ring/local injection arbiter with a bounded ring burst.
// Optional statistics counters under RING_INJECT_ARB_STATS_EN.
module ring_inject_arb
  import dii_package::*;
#(
  parameter int unsigned MAX_RING_BURST = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_ring,
  output logic    in_ring_ready,
  input  dii_flit in_local,
  output logic    in_local_ready,
  output dii_flit out_mux,
  input  logic    out_mux_ready
`ifdef RING_INJECT_ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_ring_pkts,
  output logic [15:0] stat_local_pkts
`endif
);

  localparam int unsigned CNT_W = (MAX_RING_BURST > 0) ? $clog2(MAX_RING_BURST + 1) : 1;

  ring_arb_state_t  state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             sel_ring, sel_local;
  logic             xfer_ring, xfer_local;
  logic             local_priority;

  // Saturated burst counter means the waiting local port wins the next tie.
  assign local_priority = 32'(burst_cnt_q) >= MAX_RING_BURST;

  // Nothing is granted while reset is held, even if inputs present flits.
  always_comb begin
    sel_ring  = 1'b0;
    sel_local = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (in_ring.valid && in_local.valid) begin
            sel_local = local_priority;
            sel_ring  = !local_priority;
          end else begin
            sel_ring  = in_ring.valid;
            sel_local = in_local.valid;
          end
        end
        RING:    sel_ring  = 1'b1;
        LOCAL:   sel_local = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    if (sel_ring) begin
      out_mux = in_ring;
    end else if (sel_local) begin
      out_mux = in_local;
    end else begin
      out_mux = '0;
    end
  end

  assign in_ring_ready  = sel_ring & out_mux_ready;
  assign in_local_ready = sel_local & out_mux_ready;
  assign xfer_ring      = sel_ring & in_ring.valid & out_mux_ready;
  assign xfer_local     = sel_local & in_local.valid & out_mux_ready;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer_ring) begin
          state_d = in_ring.last ? IDLE : RING;
          if (!in_local.valid) begin
            burst_cnt_d = '0;
          end else if (!local_priority) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end else if (xfer_local) begin
          state_d     = in_local.last ? IDLE : LOCAL;
          burst_cnt_d = '0;
        end
      end
      RING: begin
        if (xfer_ring && in_ring.last) state_d = IDLE;
      end
      LOCAL: begin
        if (xfer_local && in_local.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef RING_INJECT_ARB_STATS_EN
  ring_inject_arb_stats u_stats (
    .clk        (clk),
    .rst        (rst),
    .clr        (stat_clr),
    .inc_ring   (xfer_ring & in_ring.last),
    .inc_local  (xfer_local & in_local.last),
    .ring_pkts  (stat_ring_pkts),
    .local_pkts (stat_local_pkts)
  );
`endif

endmodule
